lcd_char_ctrl: RTL
==================

# lcd_char_ctrl

Parametrised HD44780-compatible character-LCD controller in 8-bit parallel mode. It performs the power-up initialisation sequence itself. It then writes an ROWS×COLS character frame, snapshotted from a flat input bus, to the panel under a refresh/busy handshake. It sits between the door-lock UI logic, which builds the text lines, and the LCD pins, and replaces the fixed 16×2, free-running line writer.

## Interface
- `COLS`, 16, characters per row (1..40)
- `ROWS`, 2, rows (1..4); row base addresses 0x80, 0xC0, 0x80+COLS, 0xC0+COLS
- `T_PWR`, 2000, power-up wait in clk cycles before the first command
- `T_SU`, 4, cycles RS/DATA are stable before E rises
- `T_PW`, 20, cycles E is held high
- `T_GAP`, 20, cycles after E falls before the next byte starts
- `T_CLR`, 300, extra wait after the clear command (0x01)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `line_data`  in  ROWS*COLS*8  frame text; row 0 in the MSBs; within a row the leftmost char occupies the most significant byte
- `refresh`  in  1  request to write a new frame; sampled every cycle
- `busy`  out  1  high during init or while a frame write is in progress
- `init_done`  out  1  high once the init sequence has completed; sticky until reset
- `rs`  out  1  LCD register select (0 = command, 1 = data)
- `e`  out  1  LCD enable strobe
- `data`  out  8  LCD data bus

## Operation
- Reset values: rs=0, e=0, data=0x00, busy=1, init_done=0, pending=0. The FSM enters PWR.
- States: PWR → INIT → IDLE → SNAP → ADDR → CHAR → (ADDR of next row | IDLE).
- PWR: counts T_PWR cycles, then moves to INIT.
- INIT: writes the commands 0x30, 0x30, 0x38, 0x0C, 0x01, 0x06 in order. After 0x01 an additional T_CLR wait cycles are inserted. When the sequence ends, init_done=1 and the FSM goes to IDLE.
- Byte write (shared by INIT/ADDR/CHAR):
  - rs and data are driven for the whole byte.
  - e=0 for T_SU cycles, then e=1 for T_PW cycles, then e=0 for T_GAP cycles.
  - Byte length B = T_SU+T_PW+T_GAP cycles.
- IDLE: busy=0. When refresh=1 or pending=1, the FSM goes to SNAP and clears pending.
- SNAP: latches line_data into an internal frame register in a single cycle. Row index and column pointer reset to 0.
- ADDR: writes the row base address with rs=0, then goes to CHAR.
- CHAR: writes the snapshot byte at (row, col) with rs=1.
  - At col=COLS-1, a non-final row goes to ADDR for row+1; the final row goes to IDLE.
  - Changes to line_data during a frame have no effect on that frame.
- refresh=1 while busy (including during init) sets pending. Multiple requests coalesce into a single pending frame, which is serviced on entry to IDLE.
- Counters must be sized with $clog2 of the largest timing parameter. No counter may wrap inside a state.

## Timing
- Init duration: T_PWR + 6·B + T_CLR cycles from reset release to init_done=1.
- Refresh sampled high in IDLE at edge N: busy=1 from edge N+1. SNAP occupies cycle N+1, and the first e rise of the ADDR byte occurs T_SU cycles after that.
- Frame duration: 1 + ROWS·(COLS+1)·B cycles, from SNAP until busy falls.
- busy falls in the same cycle the FSM enters IDLE. A refresh or pending request seen there starts a new frame on the next edge.
- Assertion of rst_n=0 mid-frame forces all outputs to their reset values immediately, including e=0. After release the full init sequence repeats.

## Configuration
- `LCD_AUTO_REFRESH_EN`
  - Defined: in IDLE, the controller also compares line_data against the last snapshot every cycle. Any difference is treated as a refresh request, so the panel tracks line_data without the host pulsing refresh.
  - Undefined: frames are written only on refresh/pending, and no comparator is built.

## Test plan
- Reset/init: with T_PWR=20, T_SU=2, T_PW=3, T_GAP=2, T_CLR=10 (B=7), release rst_n → e-pulses carry 0x30,0x30,0x38,0x0C,0x01,0x06 with rs=0, and init_done rises exactly 20+42+10=72 cycles after release.
- Frame: COLS=4, ROWS=2, line_data = "ABCD" then "WXYZ", one refresh pulse → bytes 0x80, 'A','B','C','D', 0xC0, 'W','X','Y','Z', with rs=0 only on the address bytes; busy is high for 1+2·5·7=71 cycles.
- Snapshot: change line_data to "1234…" two cycles after SNAP → the frame still outputs "ABCDWXYZ".
- Coalescing: three refresh pulses during a frame → exactly one further frame follows, and busy stays high for only one cycle-count gap between frames.
- Reset mid-frame: assert rst_n while e=1 → e, rs and data drop to 0 within the same cycle, busy=1, init_done=0, and the init sequence restarts.
- Four-row addressing: ROWS=4, COLS=16 → address bytes 0x80, 0xC0, 0x90, 0xD0. With LCD_AUTO_REFRESH_EN defined, a single-byte change in line_data while IDLE starts a frame without any refresh pulse.

Source files
------------

// File: rtl/lcd_char_ctrl.sv
// rtl/lcd_char_ctrl.sv - HD44780 8-bit character LCD controller with init sequence and frame writer
//
// Runs the power-up initialisation itself, then writes a ROWS x COLS frame,
// snapshotted from line_data, whenever refresh (or a coalesced pending request)
// is seen in IDLE.
// Optional feature macro: LCD_AUTO_REFRESH_EN (IDLE also starts a frame when
// line_data differs from the last snapshot).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   line_data  frame text, row 0 / leftmost char in the MSBs
//   refresh    frame write request, sampled every cycle
//   busy       high during init and while a frame is being written
//   init_done  sticky, high once the init sequence has completed
//   rs, e      LCD register select and enable strobe
//   data       LCD data bus
module lcd_char_ctrl #(
  parameter int COLS  = 16,
  parameter int ROWS  = 2,
  parameter int T_PWR = 2000,
  parameter int T_SU  = 4,
  parameter int T_PW  = 20,
  parameter int T_GAP = 20,
  parameter int T_CLR = 300
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS*COLS*8-1:0] line_data,
  input  logic                   refresh,
  output logic                   busy,
  output logic                   init_done,
  output logic                   rs,
  output logic                   e,
  output logic [7:0]             data
);

  localparam int B     = T_SU + T_PW + T_GAP;
  // The clear byte is stretched by T_CLR inside one count, so the counter must
  // hold the longer of the power-up wait and that stretched byte.
  localparam int T_MAX = (T_PWR > B + T_CLR) ? T_PWR : B + T_CLR;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int NCH   = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] C_PWR_LAST = CW'(T_PWR - 1);
  localparam logic [CW-1:0] C_B_LAST   = CW'(B - 1);
  localparam logic [CW-1:0] C_CLR_LAST = CW'(B + T_CLR - 1);
  localparam logic [CW-1:0] C_E_START  = CW'(T_SU);
  localparam logic [CW-1:0] C_E_END    = CW'(T_SU + T_PW);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(ROWS - 1);
  localparam logic [KW-1:0] C_COL_LAST = KW'(COLS - 1);

  localparam logic [2:0] S_PWR  = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd2;
  localparam logic [2:0] S_SNAP = 3'd3;
  localparam logic [2:0] S_ADDR = 3'd4;
  localparam logic [2:0] S_CHAR = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [2:0]               idx_q, idx_d;
  logic [RW-1:0]            row_q, row_d;
  logic [KW-1:0]            col_q, col_d;
  logic                     pending_q, pending_d;
  logic                     init_done_q, init_done_d;
  logic                     busy_q, rs_q, rs_d, e_q, e_d;
  logic [7:0]               data_q, data_d;
  logic [NCH-1:0][7:0]      frame_q;
  logic [IW-1:0]            ch_idx;
  logic                     byte_last, in_byte, req;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    init_cmd = 8'h30;
      3'd1:    init_cmd = 8'h30;
      3'd2:    init_cmd = 8'h38;
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h01;
      3'd5:    init_cmd = 8'h06;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    case (2'(r))
      2'd0:    row_base = 8'h80;
      2'd1:    row_base = 8'hC0;
      2'd2:    row_base = 8'h80 + 8'(COLS);
      default: row_base = 8'hC0 + 8'(COLS);
    endcase
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  assign req = refresh | pending_q | (line_data != frame_q);
`else
  assign req = refresh | pending_q;
`endif

  assign cnt_inc   = cnt_q + CW'(1);
  // Only the clear command (init index 4) carries the extra settle time.
  assign byte_last = (state_q == S_INIT && idx_q == 3'd4) ? (cnt_q == C_CLR_LAST)
                                                          : (cnt_q == C_B_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    init_done_d = init_done_q;
    // Requests arriving while busy collapse into one pending frame.
    pending_d   = (state_q == S_IDLE) ? 1'b0 : (pending_q | refresh);
    case (state_q)
      S_PWR: begin
        if (cnt_q == C_PWR_LAST) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_INIT: begin
        if (byte_last) begin
          cnt_d = '0;
          if (idx_q == 3'd5) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_IDLE: begin
        if (req) state_d = S_SNAP;
      end
      S_SNAP: begin
        state_d = S_ADDR;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end
      S_ADDR: begin
        if (byte_last) begin
          cnt_d   = '0;
          state_d = S_CHAR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_CHAR: begin
        if (byte_last) begin
          cnt_d = '0;
          if (col_q == C_COL_LAST) begin
            col_d = '0;
            if (row_q == C_ROW_LAST) begin
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_ADDR;
            end
          end else begin
            col_d = col_q + KW'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  // Leftmost char of row 0 sits in the top byte of the snapshot.
  assign ch_idx = IW'(NCH - 1) - (IW'(row_d) * IW'(COLS) + IW'(col_d));

  // Pin values are decoded from next-state so they are registered glitch-free.
  always_comb begin
    in_byte = 1'b0;
    rs_d    = 1'b0;
    data_d  = 8'h00;
    case (state_d)
      S_INIT: begin
        in_byte = 1'b1;
        data_d  = init_cmd(idx_d);
      end
      S_ADDR: begin
        in_byte = 1'b1;
        data_d  = row_base(row_d);
      end
      S_CHAR: begin
        in_byte = 1'b1;
        rs_d    = 1'b1;
        data_d  = frame_q[ch_idx];
      end
      default: ;
    endcase
    e_d = in_byte && (cnt_d >= C_E_START) && (cnt_d < C_E_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PWR;
      cnt_q       <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      busy_q      <= (state_d != S_IDLE);
      rs_q        <= rs_d;
      e_q         <= e_d;
      data_q      <= data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (state_q == S_SNAP) begin
      frame_q <= line_data;
    end
  end

  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign rs        = rs_q;
  assign e         = e_q;
  assign data      = data_q;

endmodule
